imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//   Buffered RV32I/RV64I immediate generator, successor to the ID-stage sign extender.
//   - Decodes all five immediate formats (I/S/B/U/J), including shift-amount immediates.
//   - Sits between the ID pipeline register and the EX operand muxes.
//   - Valid/ready handshake on both sides, with a DEPTH-entry result FIFO so EX stalls
//     do not need to back-pressure fetch on the same cycle.
// PARAMETERS
//   XLEN   32  datapath width; 32 or 64; immediates sign-extended to XLEN
//   DEPTH  2   result FIFO entries, >=1, need not be a power of two
// PORTS
//   clk_i        in   1     clock, rising edge
//   rst_i        in   1     asynchronous reset, active-high
//   flush_i      in   1     synchronous flush of all buffered entries
//   in_valid_i   in   1     ins_i is valid
//   in_ready_o   out  1     FIFO can accept an instruction this cycle
//   ins_i        in   32    instruction word
//   out_valid_o  out  1     head entry valid
//   out_ready_i  in   1     consumer takes head entry this cycle
//   imm_o        out  XLEN  head immediate; 0 when FIFO empty
//   fmt_o        out  3     head format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; 0 when empty
//   illegal_o    out  1     present only with IMM_GEN_ILLEGAL_EN; head entry illegal flag
// BEHAVIOUR
//   Handshake rules
//   - Push when in_valid_i && in_ready_o. Pop when out_valid_o && out_ready_i.
//   - in_ready_o = (count != DEPTH). There is no same-cycle pass-through when full.
//   - out_valid_o = (count != 0).
//   - Latency: an instruction accepted in cycle N is at the head in cycle N+1 if the
//     FIFO was empty; otherwise it is behind older entries, strictly in order.
//   - Simultaneous push and pop (not full): count unchanged, both pointers advance.
//   - Pointers wrap DEPTH-1 -> 0 by explicit compare. count is $clog2(DEPTH+1) bits.
//   Decode (combinational on ins_i, result written into the FIFO entry)
//   - I: opcodes 0010011, 0000011, 1100111 -> sext(ins[31:20]).
//     Exception: OP-IMM with funct3 001 or 101 -> zext shamt: ins[24:20] for XLEN=32,
//     ins[25:20] for XLEN=64; funct7 bits are excluded.
//   - S: 0100011 -> sext({ins[31:25], ins[11:7]}).
//   - B: 1100011 -> sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}). This is a byte
//     offset with bit 0 forced to 0.
//   - U: 0110111, 0010111 -> sext({ins[31:12], 12'b0}). Upper bits are sign-extended
//     for XLEN=64.
//   - J: 1101111 -> sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}).
//   - Any other opcode -> imm 0, fmt NONE.
//   Flush and reset
//   - flush_i: count and pointers cleared at the clock edge. flush_i beats a same-cycle
//     push, which is dropped. out_valid_o is 0 and in_ready_o is 1 in the next cycle.
//   - rst_i, asynchronous at any time: count 0, pointers 0, out_valid_o 0, imm_o 0,
//     fmt_o 0, illegal_o 0, in_ready_o 1. In-flight entries are discarded. Nothing is
//     pushed on the first edge after rst_i deasserts unless in_valid_i is high.
//   - Push while full is ignored; the producer must hold ins_i.
// CONFIGURATION
//   IMM_GEN_ILLEGAL_EN defined:
//   - Adds port illegal_o and one flag bit per FIFO entry.
//   - Flag is set when ins_i[1:0] != 2'b11 or the opcode is not in the decode table.
//   - Illegal entries still carry imm 0, fmt NONE.
//   IMM_GEN_ILLEGAL_EN undefined:
//   - Port and storage are absent.
//   - Unknown opcodes silently produce imm 0, fmt NONE.
// TESTING  (XLEN=32, DEPTH=2 unless noted)
//   1. addi 0xFFF00093 pushed into empty FIFO, out_ready_i=1 -> next cycle
//      out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1.
//   2. beq 0xFE000EE3 -> imm 0xFFFFFFFC, fmt 3.
//      jal 0x0080006F -> imm 0x00000008, fmt 5.
//      lui 0x123450B7 -> imm 0x12345000, fmt 4.
//      sw 0x00112223 -> imm 0x00000004, fmt 2.
//   3. slli 0x00309093 -> imm 3. srai 0x4030D093 -> imm 3 (not 0x403).
//      XLEN=64: srai 0x43F0D093 -> imm 63.
//   4. out_ready_i=0; push A, B, C back-to-back -> in_ready_o=0 after B, C not accepted.
//      Then out_ready_i=1 -> A, then B, then C after re-push; no loss, no duplicates.
//   5. Two entries held; flush_i=1 together with a push -> next cycle out_valid_o=0,
//      in_ready_o=1, and the pushed word is absent.
//   6. rst_i pulsed mid-cycle with 2 entries held -> outputs 0 immediately, without
//      waiting for a clock. With IMM_GEN_ILLEGAL_EN: 0x00000013 -> illegal_o=0;
//      0x0000007F -> illegal_o=1, fmt 0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate decoder feeding a DEPTH-entry valid/ready result FIFO.
// IMM_GEN_ILLEGAL_EN adds a per-entry illegal flag and the illegal_o port.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     ins_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic            illegal_o
`endif
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef IMM_GEN_ILLEGAL_EN
    localparam int EW = XLEN + 4;
`else
    localparam int EW = XLEN + 3;
`endif

    logic [6:0]      op;
    logic [2:0]      f3;
    logic            is_i, is_sh, is_s, is_b, is_u, is_j;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d;
    logic [2:0]      fmt_d;
    logic [EW-1:0]   ent_d, head;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    assign op    = ins_i[6:0];
    assign f3    = ins_i[14:12];
    assign is_i  = op == 7'h13 || op == 7'h03 || op == 7'h67;
    assign is_sh = op == 7'h13 && (f3 == 3'b001 || f3 == 3'b101);
    assign is_s  = op == 7'h23;
    assign is_b  = op == 7'h63;
    assign is_u  = op == 7'h37 || op == 7'h17;
    assign is_j  = op == 7'h6f;

    // Every format fits in 32 bits; shamt is positive so sign extension widens it correctly.
    assign imm32 = is_sh ? (XLEN == 64 ? {26'b0, ins_i[25:20]} : {27'b0, ins_i[24:20]}) :
                   is_i  ? {{20{ins_i[31]}}, ins_i[31:20]} :
                   is_s  ? {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]} :
                   is_b  ? {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0} :
                   is_u  ? {ins_i[31:12], 12'b0} :
                   is_j  ? {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0} :
                           32'b0;
    assign imm_d = XLEN'($signed(imm32));
    assign fmt_d = is_i ? 3'd1 : is_s ? 3'd2 : is_b ? 3'd3 : is_u ? 3'd4 : is_j ? 3'd5 : 3'd0;

`ifdef IMM_GEN_ILLEGAL_EN
    assign ent_d     = {ins_i[1:0] != 2'b11 || fmt_d == 3'd0, fmt_d, imm_d};
    assign illegal_o = head[EW-1];
`else
    assign ent_d = {fmt_d, imm_d};
`endif

    assign in_ready_o  = count_q != CW'(DEPTH);
    assign out_valid_o = count_q != '0;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign head        = out_valid_o ? mem_q[rd_q] : '0;
    assign imm_o       = head[XLEN-1:0];
    assign fmt_o       = head[XLEN+2:XLEN];

    assign wr_d    = flush_i ? '0 : push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    assign rd_d    = flush_i ? '0 : pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    assign count_d = flush_i ? '0 : count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem_q[wr_q] <= ent_d;
    end
endmodule
